dco_freq_meter: RTL and testbench



---
 rtl/adpll_meas_pkg.sv | 14 +
 rtl/sat_counter.sv | 42 ++++
 rtl/dco_freq_meter.sv | 89 ++++++++
 tb/tb_dco_freq_meter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/adpll_meas_pkg.sv
// Shared types and constants for the ADPLL frequency-measurement blocks.
package adpll_meas_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int WIN_W_DEF = 12;
  localparam int CNT_MAX   = (1 << CNT_W_DEF) - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } meas_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, enable and a sticky overflow flag.
// Exposes its next-state view so the owner can capture a total that includes this cycle's increment.
module sat_counter
  import adpll_meas_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] value_nxt,
  output logic         ovf_nxt
);

  logic [W-1:0] value;
  logic         ovf;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    value_nxt = value;
    ovf_nxt   = ovf;
    if (clr) begin
      value_nxt = '0;
      ovf_nxt   = 1'b0;
    end else if (en) begin
      if (value == '1) ovf_nxt   = 1'b1;
      else             value_nxt = value + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
      ovf   <= 1'b0;
    end else begin
      value <= value_nxt;
      ovf   <= ovf_nxt;
    end
  end

endmodule

// File: rtl/dco_freq_meter.sv
// Counts synchronized DCO ticks over a window of N reference cycles and
// hands the result to the loop controller through a valid/ready handshake.
module dco_freq_meter
  import adpll_meas_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic             tick,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  meas_state_e      state;
  logic [WIN_W-1:0] win_cnt;
  logic             acc_clr;
  logic             acc_en;
  logic [CNT_W-1:0] acc_nxt;
  logic             acc_ovf_nxt;

  assign acc_clr = (state == IDLE) && start;
  assign acc_en  = (state == COUNT) && tick;

  sat_counter #(.W(CNT_W)) u_acc (
    .clk       (clk),
    .rst       (rst),
    .clr       (acc_clr),
    .en        (acc_en),
    .value_nxt (acc_nxt),
    .ovf_nxt   (acc_ovf_nxt)
  );

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      win_cnt   <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (win_len != '0) begin
              win_cnt <= win_len - 1'b1;
              state   <= COUNT;
            end else begin
              state     <= HOLD;
              res_valid <= 1'b1;
              count     <= '0;
              overflow  <= 1'b0;
            end
          end
        end
        COUNT: begin
          // The last window cycle's tick is already folded into acc_nxt.
          if (win_cnt == '0) begin
            state     <= HOLD;
            res_valid <= 1'b1;
            count     <= acc_nxt;
            overflow  <= acc_ovf_nxt;
          end else begin
            win_cnt <= win_cnt - 1'b1;
          end
        end
        HOLD: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dco_freq_meter.sv
// Scoreboard bench for dco_freq_meter: a 16-bit and a 4-bit instance share stimulus;
// expected results come from counting the ticks placed inside each window.
module tb_dco_freq_meter;

  typedef struct {
    int unsigned cnt;
    bit          ovf;
  } res_t;

  typedef enum int {P_ALL, P_EVERY3, P_EDGES, P_NONE, P_RAND} pat_e;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] win_len = '0;
  logic        tick = 1'b0;
  logic        res_ready = 1'b0;

  logic        busy16, rv16, ovf16;
  logic [15:0] cnt16;
  logic        busy4, rv4, ovf4;
  logic [3:0]  cnt4;

  int checks = 0;
  int errors = 0;

  res_t q16[$];
  res_t q4[$];
  bit   pat [4096];

  always #5 clk = ~clk;

  dco_freq_meter #(.CNT_W(16), .WIN_W(12)) dut16 (
    .clk(clk), .rst(rst), .start(start), .win_len(win_len), .tick(tick),
    .busy(busy16), .res_valid(rv16), .res_ready(res_ready),
    .count(cnt16), .overflow(ovf16)
  );

  dco_freq_meter #(.CNT_W(4), .WIN_W(12)) dut4 (
    .clk(clk), .rst(rst), .start(start), .win_len(win_len), .tick(tick),
    .busy(busy4), .res_valid(rv4), .res_ready(res_ready),
    .count(cnt4), .overflow(ovf4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every presented result against the queue head, pops on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (rv16) begin
        if (q16.size() == 0) check("rv16_unexpected", 1, 0);
        else begin
          check("count16", cnt16, q16[0].cnt);
          check("ovf16", ovf16, q16[0].ovf);
          if (res_ready) void'(q16.pop_front());
        end
      end
      if (rv4) begin
        if (q4.size() == 0) check("rv4_unexpected", 1, 0);
        else begin
          check("count4", cnt4, q4[0].cnt);
          check("ovf4", ovf4, q4[0].ovf);
          if (res_ready) void'(q4.pop_front());
        end
      end
    end
  end

  task automatic run_meas(input int n, input pat_e mode, input int hold,
                          input bit start_in_count, input bit start_with_ready);
    int   pop;
    res_t e16, e4;
    pop = 0;
    for (int i = 0; i < n; i++) begin
      case (mode)
        P_ALL:    pat[i] = 1'b1;
        P_EVERY3: pat[i] = (i % 3 == 0);
        P_EDGES:  pat[i] = (i == 0) || (i == n - 1);
        P_NONE:   pat[i] = 1'b0;
        default:  pat[i] = 1'($urandom_range(0, 1));
      endcase
      pop += int'(pat[i]);
    end
    e16.cnt = (pop > 65535) ? 65535 : pop;
    e16.ovf = (pop > 65535);
    e4.cnt  = (pop > 15) ? 15 : pop;
    e4.ovf  = (pop > 15);
    q16.push_back(e16);
    q4.push_back(e4);

    // Start cycle: tick here falls in IDLE and must not count.
    start = 1'b1; win_len = 12'(n); tick = 1'b1; res_ready = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick      = pat[i];
      start     = start_in_count;
      win_len   = 12'($urandom);
      res_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (i == n - 1) check("early_rv", rv16, 0);
      step();
    end
    // First HOLD cycle: tick here must not count either.
    tick = 1'b1; start = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    check("latency_rv16", rv16, 1);
    check("latency_rv4", rv4, 1);
    check("hold_busy", busy16, 1);
    step();
    for (int h = 0; h < hold; h++) begin
      tick = 1'($urandom_range(0, 1));
      step();
    end
    res_ready = 1'b1;
    start     = start_with_ready;
    win_len   = 12'd5;
    step();
    res_ready = 1'b0; start = 1'b0; tick = 1'b0;
    @(negedge clk);
    check("idle_busy16", busy16, 0);
    check("idle_busy4", busy4, 0);
    check("idle_rv", rv16, 0);
    check("idle_keep16", cnt16, e16.cnt);
    check("idle_keep4", cnt4, e4.cnt);
    check("idle_keep_ovf4", ovf4, e4.ovf);
    step();
  endtask

  task automatic reset_mid();
    start = 1'b1; win_len = 12'd50; tick = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy16, 0);
    check("rst_rv", rv16, 0);
    check("rst_count16", cnt16, 0);
    check("rst_ovf16", ovf16, 0);
    check("rst_count4", cnt4, 0);
    check("rst_ovf4", ovf4, 0);
    step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", busy16, 0);
    check("reset_rv", rv16, 0);
    check("reset_count", cnt16, 0);
    check("reset_ovf", ovf16, 0);
    step();

    run_meas(10, P_ALL, 5, 1'b0, 1'b0);     // basic window, held result
    run_meas(100, P_EVERY3, 0, 1'b0, 1'b0); // sparse ticks -> 34
    run_meas(4, P_EDGES, 1, 1'b0, 1'b0);    // window-edge ticks -> 2
    run_meas(20, P_ALL, 2, 1'b0, 1'b0);     // 4-bit instance saturates
    run_meas(20, P_NONE, 0, 1'b0, 1'b0);    // overflow cleared on new run
    run_meas(0, P_ALL, 1, 1'b0, 1'b1);      // zero window, start with handshake ignored
    run_meas(8, P_RAND, 1, 1'b1, 1'b1);     // start during COUNT ignored
    run_meas(1, P_ALL, 0, 1'b0, 0);         // single-cycle window

    run_meas(30, P_ALL, 0, 1'b0, 1'b0);
    reset_mid();
    run_meas(3, P_ALL, 0, 1'b0, 1'b0);

    for (int r = 0; r < 30; r++) begin
      run_meas(int'($urandom_range(0, 300)), pat_e'($urandom_range(0, 4)),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
    end

    check("queue_drained", 32'(q16.size() + q4.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
